// File: rtl/bht_predictor.sv
// Branch history table: 2-bit saturating counters indexed by PC, with registered taken/not-taken prediction.
// Latency: lookup result 1 cycle after the request; an update is visible to lookups from the following cycle.
// Backpressure: none; a lookup and an update are accepted every cycle (updates are dropped in debug mode or on flush).
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   flush_i                      synchronous invalidate of every entry and of the pending update
//   debug_mode_i                 suppresses updates (and mispredict counting)
//   lookup_valid_i, lookup_pc_i  frontend prediction request
//   pred_valid_o, pred_taken_o   registered prediction for the previous cycle's request
//   update_valid_i, update_pc_i, update_taken_i, update_mispredict_i
//                                resolved conditional branch from the branch unit
//   mispredict_cnt_o             saturating count of accepted mispredicted updates

module bht_predictor #(
    parameter int unsigned NR_ENTRIES  = 64,
    parameter int unsigned VLEN        = 64,
    parameter int unsigned INSTR_ALIGN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] lookup_pc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    input  logic            update_valid_i,
    input  logic [VLEN-1:0] update_pc_i,
    input  logic            update_taken_i,
    input  logic            update_mispredict_i,
    output logic [15:0]     mispredict_cnt_o
);

    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

    // Counter value an entry takes whenever it is (re)initialised: weakly not-taken.
    localparam logic [1:0] CNT_INIT = 2'b01;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [NR_ENTRIES-1:0] tbl_valid;
    logic [1:0]            tbl_cnt [NR_ENTRIES];

    // Pending update: written into the table one cycle after acceptance.
    logic                  upd_valid_q;
    logic [IDX_W-1:0]      upd_idx_q;
    logic [1:0]            upd_cnt_q;

    logic                  pred_valid_q;
    logic                  pred_taken_q;
    logic [15:0]           mis_cnt_q;

    // ------------------------------------------------------------------
    // Indexing (no tag; aliasing between PCs is accepted)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;

    assign lookup_idx = lookup_pc_i[IDX_W+INSTR_ALIGN-1:INSTR_ALIGN];
    assign update_idx = update_pc_i[IDX_W+INSTR_ALIGN-1:INSTR_ALIGN];

    // Only the index bits of the PCs matter; the rest are folded away here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i, update_pc_i};

    // ------------------------------------------------------------------
    // Effective entry: the pending update overrides the stored entry so
    // that neither a lookup nor a back-to-back update misses it.
    // ------------------------------------------------------------------
    logic       lk_fwd;
    logic       lk_valid;
    logic [1:0] lk_cnt;

    logic       up_fwd;
    logic       up_valid;
    logic [1:0] up_cnt;

    always_comb begin
        lk_fwd   = upd_valid_q && (upd_idx_q == lookup_idx);
        lk_valid = lk_fwd | tbl_valid[lookup_idx];
        lk_cnt   = lk_fwd ? upd_cnt_q : tbl_cnt[lookup_idx];

        up_fwd   = upd_valid_q && (upd_idx_q == update_idx);
        up_valid = up_fwd | tbl_valid[update_idx];
        up_cnt   = up_fwd ? upd_cnt_q : tbl_cnt[update_idx];
    end

    // ------------------------------------------------------------------
    // Update acceptance and next counter value
    // ------------------------------------------------------------------
    logic       upd_accept;
    logic [1:0] upd_new_cnt;

    assign upd_accept = update_valid_i & ~debug_mode_i & ~flush_i;

    always_comb begin
        upd_new_cnt = CNT_INIT;
        if (!up_valid) begin
            // First sighting of this index: start just on the outcome's side.
            upd_new_cnt = update_taken_i ? 2'b10 : 2'b01;
        end else if (update_taken_i) begin
            upd_new_cnt = (up_cnt == 2'b11) ? 2'b11 : up_cnt + 2'b01;
        end else begin
            upd_new_cnt = (up_cnt == 2'b00) ? 2'b00 : up_cnt - 2'b01;
        end
    end

    // ------------------------------------------------------------------
    // Pending-update register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_cnt_q   <= CNT_INIT;
        end else begin
            // flush_i already blocks acceptance, which discards the pending slot.
            upd_valid_q <= upd_accept;
            if (upd_accept) begin
                upd_idx_q <= update_idx;
                upd_cnt_q <= upd_new_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Table write: flush wins over the pending write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tbl_valid <= '0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                tbl_cnt[i] <= CNT_INIT;
            end
        end else if (flush_i) begin
            tbl_valid <= '0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                tbl_cnt[i] <= CNT_INIT;
            end
        end else if (upd_valid_q) begin
            tbl_valid[upd_idx_q] <= 1'b1;
            tbl_cnt[upd_idx_q]   <= upd_cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Registered prediction. A same-cycle update is deliberately not
    // visible: it only reaches upd_q at this same edge.
    // ------------------------------------------------------------------
    logic pred_hit;
    assign pred_hit = lookup_valid_i & lk_valid & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            pred_valid_q <= pred_hit;
            pred_taken_q <= pred_hit & lk_cnt[1];
        end
    end

    // ------------------------------------------------------------------
    // Mispredict counter: saturating, survives flush.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mis_cnt_q <= '0;
        end else if (upd_accept && update_mispredict_i && (mis_cnt_q != 16'hFFFF)) begin
            mis_cnt_q <= mis_cnt_q + 16'd1;
        end
    end

    assign pred_valid_o     = pred_valid_q;
    assign pred_taken_o     = pred_taken_q;
    assign mispredict_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: directed vectors, expected predictions queued at issue
// and compared by an independent monitor when the registered result appears.
// Mispredict counter and reset state are compared against hand-computed constants.

module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        dbg;
    logic        lv;
    logic [63:0] lpc;
    logic        pv;
    logic        pt;
    logic        uv;
    logic [63:0] upc;
    logic        ut;
    logic        um;
    logic [15:0] mc;

    bht_predictor #(
        .NR_ENTRIES  (64),
        .VLEN        (64),
        .INSTR_ALIGN (1)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .flush_i             (flush),
        .debug_mode_i        (dbg),
        .lookup_valid_i      (lv),
        .lookup_pc_i         (lpc),
        .pred_valid_o        (pv),
        .pred_taken_o        (pt),
        .update_valid_i      (uv),
        .update_pc_i         (upc),
        .update_taken_i      (ut),
        .update_mispredict_i (um),
        .mispredict_cnt_o    (mc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic v;
        logic t;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic lk_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) lk_d <= 1'b0;
        else     lk_d <= lv;
    end

    always @(negedge clk) begin
        exp_t e;
        if (lk_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pred_unexpected: got prediction %0b/%0b with nothing queued", pv, pt);
            end else begin
                e = exp_q.pop_front();
                check("pred_valid", {31'd0, pv}, {31'd0, e.v});
                check("pred_taken", {31'd0, pt}, {31'd0, e.t});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic l, input logic [63:0] lp,
                         input logic u, input logic [63:0] up, input logic t, input logic m,
                         input logic f, input logic d, input exp_t e);
        @(negedge clk);
        lv = l; lpc = lp; uv = u; upc = up; ut = t; um = m; flush = f; dbg = d;
        if (l) exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic upd(input logic [63:0] pc, input logic t, input logic m);
        drive(1'b0, 64'h0, 1'b1, pc, t, m, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic look(input logic [63:0] pc, input logic v, input logic t);
        drive(1'b1, pc, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, {v, t});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; flush = 0; dbg = 0; lv = 0; lpc = 0; uv = 0; upc = 0; ut = 0; um = 0;
        #3;
        check("reset_pred_valid", {31'd0, pv}, 32'd0);
        check("reset_pred_taken", {31'd0, pt}, 32'd0);
        check("reset_mis_cnt", {16'd0, mc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Update then lookup via forwarding, then again from the table.
        upd(64'h1000, 1'b1, 1'b1);
        look(64'h1000, 1'b1, 1'b1);
        look(64'h1000, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle while a valid prediction is showing.
        @(posedge clk);
        #2;
        check("pre_reset_pred_valid", {31'd0, pv}, 32'd1);
        check("pre_reset_mis_cnt", {16'd0, mc}, 32'd1);
        lv = 0; uv = 0; um = 0;
        rst = 1'b1;
        #1;
        check("async_reset_pred_valid", {31'd0, pv}, 32'd0);
        check("async_reset_pred_taken", {31'd0, pt}, 32'd0);
        check("async_reset_mis_cnt", {16'd0, mc}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        look(64'h1000, 1'b0, 1'b0);

        // Same-cycle update is invisible; next cycle sees it.
        drive(1'b1, 64'h8000_0040, 1'b1, 64'h8000_0040, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        look(64'h8000_0040, 1'b1, 1'b1);
        idle();
        look(64'h8000_0040, 1'b1, 1'b1);

        // Saturation on PC 0x100: 10,11,11,11 then down to 00 and back.
        repeat (4) upd(64'h100, 1'b1, 1'b0);
        look(64'h100, 1'b1, 1'b1);               // 11
        upd(64'h100, 1'b0, 1'b0);
        look(64'h100, 1'b1, 1'b1);               // 10
        upd(64'h100, 1'b0, 1'b0);
        look(64'h100, 1'b1, 1'b0);               // 01
        upd(64'h100, 1'b0, 1'b0);                // 00
        upd(64'h100, 1'b0, 1'b0);                // stays 00
        upd(64'h100, 1'b1, 1'b0);                // 01
        look(64'h100, 1'b1, 1'b0);
        upd(64'h100, 1'b1, 1'b0);                // 10
        look(64'h100, 1'b1, 1'b1);

        // Aliasing: 0x0002 and 0x0082 share index 1.
        upd(64'h0002, 1'b1, 1'b0);               // 10
        upd(64'h0082, 1'b0, 1'b0);               // 01
        look(64'h0002, 1'b1, 1'b0);

        // Flush with a pending write and a simultaneous (mispredicted) update.
        upd(64'h0002, 1'b1, 1'b0);
        drive(1'b1, 64'h8000_0040, 1'b1, 64'h0082, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        look(64'h0002, 1'b0, 1'b0);
        look(64'h8000_0040, 1'b0, 1'b0);
        look(64'h0100, 1'b0, 1'b0);

        // Debug mode: updates ignored, lookups still served.
        drive(1'b0, 64'h0, 1'b1, 64'h0006, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        look(64'h0006, 1'b0, 1'b0);
        upd(64'h0004, 1'b1, 1'b0);               // 10
        drive(1'b1, 64'h0004, 1'b1, 64'h0004, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
        look(64'h0004, 1'b1, 1'b1);
        idle();
        check("mis_cnt_after_flush_debug", {16'd0, mc}, 32'd0);

        // Saturating mispredict counter: 65534, then 6 more (65540 total).
        for (int i = 0; i < 65534; i++) upd(64'h200, i[0], 1'b1);
        idle();
        check("mis_cnt_65534", {16'd0, mc}, 32'h0000_FFFE);
        for (int i = 0; i < 6; i++) upd(64'h200, 1'b1, 1'b1);
        idle();
        check("mis_cnt_saturated", {16'd0, mc}, 32'h0000_FFFF);
        drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        idle();
        check("mis_cnt_after_flush", {16'd0, mc}, 32'h0000_FFFF);
        look(64'h200, 1'b0, 1'b0);

        idle();
        idle();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Branch history table that consumes the resolved-branch stream produced by the execute-stage branch unit.
- Returns a registered taken/not-taken prediction to the frontend for a looked-up PC.
- Holds one 2-bit saturating counter plus valid bit per entry, in flops.
- Registers each update for one cycle before writing the table, with forwarding so lookups and back-to-back updates see the pending write.

Parameters:
- NR_ENTRIES, 64, number of table entries; power of two, >= 2.
- VLEN, riscv::VLEN, virtual address width.
- INSTR_ALIGN, 1, low PC bits dropped before indexing (1 = compressed instructions supported).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  synchronous table invalidate.
- debug_mode_i  in  1  core is in debug mode; suppresses updates.
- lookup_valid_i  in  1  frontend lookup request this cycle.
- lookup_pc_i  in  VLEN  PC to predict.
- pred_valid_o  out  1  registered: the lookup hit a valid entry.
- pred_taken_o  out  1  registered: predicted taken (counter MSB).
- update_valid_i  in  1  resolved conditional branch from the branch unit.
- update_pc_i  in  VLEN  PC of the resolved branch.
- update_taken_i  in  1  actual branch outcome.
- update_mispredict_i  in  1  the branch was mispredicted.
- mispredict_cnt_o  out  16  saturating count of accepted mispredicted updates.

Behaviour:
- Index: idx(pc) = pc[$clog2(NR_ENTRIES)+INSTR_ALIGN-1 : INSTR_ALIGN]. No tag; aliasing is allowed.
- Reset (rst_i=1, asynchronous), applied immediately:
  - all entries: valid=0, counter=2'b01;
  - pending-update register upd_q cleared;
  - pred_valid_o=0, pred_taken_o=0, mispredict_cnt_o=0.
- Effective entry E(i) in cycle t:
  - if upd_q.valid and upd_q.idx==i, E(i) = {1, upd_q.cnt};
  - otherwise E(i) = table[i].
- Lookup (latency 1):
  - pred_valid_o(t+1) = lookup_valid_i(t) & E(idx).valid & ~flush_i(t).
  - pred_taken_o(t+1) = E(idx).cnt[1] when pred_valid_o is set, else 0.
  - An update presented in the same cycle t as the lookup is NOT visible; updates accepted in cycle t-1 or earlier are visible.
- Update acceptance: accept = update_valid_i & ~debug_mode_i & ~flush_i.
- New counter value, computed from E(idx(update_pc_i)):
  - if E.valid=0: taken gives 2'b10, not-taken gives 2'b01;
  - if E.valid=1: taken gives min(cnt+1, 2'b11), not-taken gives max(cnt-1, 2'b00);
  - arithmetic saturates, never wraps.
- Update pipeline:
  - on accept, upd_q <= {valid=1, idx, new cnt}; otherwise upd_q.valid <= 0;
  - at the same edge, an existing valid upd_q is written into the table (table[idx] <= {1, cnt}).
- Back-to-back updates to the same index in cycles t and t+1: the second uses the forwarded value from the first, so no increment is lost.
- Flush (flush_i=1 in cycle t):
  - at the edge all entries become valid=0, counter=2'b01, and upd_q is discarded;
  - flush has priority over both the pending write and any update in cycle t;
  - pred_valid_o(t+1)=0.
- Debug mode: update_valid_i is ignored entirely, including the mispredict count. Lookups are unaffected.
- mispredict_cnt_o increments on accept & update_mispredict_i and saturates at 16'hFFFF. Flush does not clear it.
- Outputs are registered only; there is no combinational input-to-output path.

Test Plan:
- Reset: drive rst_i mid-cycle -> all outputs 0 immediately; a lookup of PC 0x1000 on the next cycle gives pred_valid_o=0.
- Update then lookup:
  - update PC 0x80000040 taken in cycle 0, lookup the same PC in cycle 1 -> cycle 2 shows pred_valid_o=1, pred_taken_o=1 (counter 10);
  - a lookup in cycle 0 instead -> pred_valid_o=0.
- Saturation:
  - four taken updates to PC 0x100 in consecutive cycles -> counter 11;
  - then one not-taken -> counter 10, pred_taken_o=1;
  - then two more not-taken -> counter 00, pred_taken_o=0.
- Aliasing: with NR_ENTRIES=64, updates to PC 0x0002 (taken) and PC 0x0082 (not-taken) hit the same index -> final counter 01, so a lookup of 0x0002 gives pred_taken_o=0.
- Flush/debug:
  - flush_i together with update_valid_i -> all entries invalid, the update is dropped, pred_valid_o=0 next cycle;
  - update with debug_mode_i=1 and update_mispredict_i=1 -> table unchanged, mispredict_cnt_o unchanged.
- Counter: 65540 accepted mispredicted updates -> mispredict_cnt_o holds at 16'hFFFF; a flush leaves it at 16'hFFFF.
